rr_arb4_sel: RTL and testbench
==============================

Name: rr_arb4_sel

Overview:
- 4-requester round-robin arbiter that produces the 2-bit select index feeding the team's 2-to-4 one-hot decoder stage directly downstream.
- Holds a grant until the owner signals done or drops its request, then rotates priority.
- An optional watchdog forces release of a stuck grant.
- Sits between requesting agents and the decoder. gnt_idx drives the decoder input; gnt_valid qualifies the decoder output.

Parameters:
- MAX_HOLD, 16: max cycles a grant may be held before forced release (watchdog build only); legal range 2..255.
- CNT_W, 8: watchdog counter width; must satisfy 2**CNT_W > MAX_HOLD.

Ports:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous active-low reset; deassertion synchronised externally.
- req  input  4  request vector; bit i = requester i.
- done  input  1  single-cycle pulse from current owner ending its tenure.
- gnt_idx  output  2  index of current owner, binary; feeds the downstream decoder.
- gnt_valid  output  1  high while a grant is held.
- busy  output  1  high in GRANT or RELEASE.
- timeout_err  output  1  one-cycle pulse on forced release.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, ptr=2'b00, gnt_idx=2'b00, gnt_valid=0, busy=0, timeout_err=0, hold counter=0. Applies immediately, including mid-grant; no done or err is emitted.
- All outputs are registered.
- States: IDLE, GRANT, RELEASE.
- IDLE:
  - If req != 0, the winner is the first set bit searching ptr, ptr+1, ptr+2, ptr+3, all mod 4.
  - Next cycle: state=GRANT, gnt_idx=winner, gnt_valid=1, busy=1, counter=0.
  - Latency from req sampled to gnt_valid high is 1 cycle.
  - If req == 0, stay in IDLE.
- GRANT:
  - gnt_idx is stable for the entire tenure; requests from other requesters are ignored.
  - Release condition: done=1, OR req[gnt_idx]=0, OR (watchdog build) counter == MAX_HOLD-1.
  - On release, next cycle: state=RELEASE, gnt_valid=0, ptr=gnt_idx+1 (2-bit wrap, 3 -> 0).
  - Otherwise the counter increments, saturating at its max.
- RELEASE:
  - Exactly 1 cycle: busy=1, gnt_valid=0, gnt_idx holds its last value. This is a guaranteed bubble so the decoder output is never valid for two owners back to back.
  - Then state=IDLE. Arbitration resumes in the following IDLE cycle, so the minimum re-grant gap is 2 cycles.
- timeout_err:
  - Asserted for exactly the RELEASE cycle that follows a watchdog release.
  - If done or a req drop coincides with the watchdog terminal count, the normal release wins and timeout_err stays 0.
- done in IDLE or RELEASE is ignored.
- req changes during RELEASE are not sampled.
- Fairness: with all 4 requesting continuously, grants go 0, 1, 2, 3, 0, ... Each requester waits at most 3 tenures.

Optional Feature:
- Macro: RR_ARB4_WATCHDOG_EN.
- Defined: counter, MAX_HOLD release and timeout_err are implemented as above.
- Undefined: no counter logic; a grant is held until done or req drop; timeout_err is tied to 0; MAX_HOLD and CNT_W are unused.

Decomposition:
- Package rr_arb4_pkg holds:
  - NUM_REQ = 4 and IDX_W = 2 constants.
  - The arb_state_t enum {IDLE, GRANT, RELEASE}.
- One sub-module: rr_pick4, combinational. Inputs req[3:0] and ptr[1:0]; outputs win_idx[1:0] and any_req. Instantiated once.

Test Plan:
- Reset mid-grant: grant to requester 2, then pull rst_n low asynchronously between edges -> gnt_valid=0, gnt_idx=0, busy=0 immediately; after release, req=4'b0001 -> gnt_idx=0 one cycle later.
- Rotation: req=4'b1111 held, done pulsed 2 cycles after each grant -> gnt_idx sequence 0, 1, 2, 3, 0. Each grant has 1 RELEASE cycle plus 1 IDLE cycle with gnt_valid=0 between grants.
- Pointer skip and wrap: after owner 3 releases, req=4'b0100 -> ptr=0 and the search yields gnt_idx=2. Next, req=4'b1001 -> gnt_idx=3.
- Request drop: grant to requester 1, deassert req[1] with no done -> gnt_valid falls next cycle, timeout_err=0, and the next winner is searched from ptr=2.
- Watchdog (macro defined, MAX_HOLD=16): owner holds req with no done -> gnt_valid is high exactly 16 cycles and timeout_err pulses 1 cycle. Repeat with done on the 16th cycle -> timeout_err=0.
- Macro undefined: owner holds for 100 cycles -> gnt_valid stays high throughout and timeout_err is never asserted.

Source files
------------

// File: rtl/rr_arb4_pkg.sv
// Shared constants and state encoding for the 4-way round-robin arbiter.
package rr_arb4_pkg;
  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;
endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping mod 4.
module rr_pick4
  import rr_arb4_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   win_idx,
  output logic               any_req
);
  logic             w_found;
  logic [IDX_W-1:0] w_cand;

  assign any_req = |req;

  always_comb begin
    win_idx = '0;
    w_found = 1'b0;
    w_cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = ptr + IDX_W'(k);
      if (!w_found && req[w_cand]) begin
        win_idx = w_cand;
        w_found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/rr_arb4_sel.sv
// Round-robin arbiter producing the select index for the downstream 2-to-4 decoder.
// Define RR_ARB4_WATCHDOG_EN to add the MAX_HOLD forced-release watchdog and timeout_err.
module rr_arb4_sel
  import rr_arb4_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_valid,
  output logic               busy,
  output logic               timeout_err
);
  if (MAX_HOLD < 2 || MAX_HOLD > 255 || (MAX_HOLD >> CNT_W) != 0) begin : g_bad_param
    $error("rr_arb4_sel: MAX_HOLD must be 2..255 and below 2**CNT_W");
  end

  arb_state_t       r_state, w_state_nxt;
  logic [IDX_W-1:0] r_ptr, w_ptr_nxt;
  logic [IDX_W-1:0] r_gnt_idx, w_idx_nxt;
  logic             r_gnt_valid, w_vld_nxt;
  logic             r_busy, w_busy_nxt;
  logic [IDX_W-1:0] w_win_idx;
  logic             w_any_req;
  logic             w_wd_hit;
  logic             w_release;

`ifdef RR_ARB4_WATCHDOG_EN
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_timeout_err, w_to_nxt;

  // Terminal count is reached on the MAX_HOLD-th cycle of a tenure.
  assign w_wd_hit    = (r_cnt == CNT_W'(MAX_HOLD - 1));
  assign timeout_err = r_timeout_err;
`else
  assign w_wd_hit    = 1'b0;
  assign timeout_err = 1'b0;
`endif

  rr_pick4 u_pick (
    .req     (req),
    .ptr     (r_ptr),
    .win_idx (w_win_idx),
    .any_req (w_any_req)
  );

  assign w_release = done | ~req[r_gnt_idx] | w_wd_hit;

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_idx_nxt   = r_gnt_idx;
    w_vld_nxt   = r_gnt_valid;
    w_busy_nxt  = r_busy;
`ifdef RR_ARB4_WATCHDOG_EN
    w_cnt_nxt   = r_cnt;
    w_to_nxt    = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (w_any_req) begin
          w_state_nxt = GRANT;
          w_idx_nxt   = w_win_idx;
          w_vld_nxt   = 1'b1;
          w_busy_nxt  = 1'b1;
`ifdef RR_ARB4_WATCHDOG_EN
          w_cnt_nxt   = '0;
`endif
        end
      end
      GRANT: begin
        if (w_release) begin
          w_state_nxt = RELEASE;
          w_vld_nxt   = 1'b0;
          w_ptr_nxt   = r_gnt_idx + 1'b1;
`ifdef RR_ARB4_WATCHDOG_EN
          // A genuine done or request drop on the terminal cycle is a normal release.
          w_to_nxt    = w_wd_hit & ~done & req[r_gnt_idx];
        end else if (r_cnt != '1) begin
          w_cnt_nxt   = r_cnt + 1'b1;
`endif
        end
      end
      RELEASE: begin
        w_state_nxt = IDLE;
        w_busy_nxt  = 1'b0;
      end
      default: begin
        w_state_nxt = IDLE;
        w_vld_nxt   = 1'b0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_gnt_idx   <= '0;
      r_gnt_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_gnt_idx   <= w_idx_nxt;
      r_gnt_valid <= w_vld_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

`ifdef RR_ARB4_WATCHDOG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt         <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_cnt         <= w_cnt_nxt;
      r_timeout_err <= w_to_nxt;
    end
  end
`endif

  assign gnt_idx   = r_gnt_idx;
  assign gnt_valid = r_gnt_valid;
  assign busy      = r_busy;
endmodule

// File: tb/tb_rr_arb4_sel.sv
// Self-checking bench for rr_arb4_sel against a transaction-level round-robin model.
module tb_rr_arb4_sel;
  localparam int MAX_HOLD = 16;
  localparam int CNT_W    = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic [1:0] gnt_idx;
  logic       gnt_valid, busy, timeout_err;

  int n_vec = 0;
  int n_err = 0;

  // Model: phase 0 = idle, 1 = owner holds, 2 = bubble.
  int m_st, m_ptr, m_idx, m_cnt;
  bit m_vld, m_busy, m_to;

  always #5 clk = ~clk;

  rr_arb4_sel #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .done        (done),
    .gnt_idx     (gnt_idx),
    .gnt_valid   (gnt_valid),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  task automatic m_reset();
    m_st = 0; m_ptr = 0; m_idx = 0; m_cnt = 0;
    m_vld = 0; m_busy = 0; m_to = 0;
  endtask

  task automatic m_clock(input logic [3:0] r, input logic d);
    bit wd;
    bit found;
    m_to = 0;
    case (m_st)
      0: if (r != 4'b0000) begin
        found = 0;
        for (int k = 0; k < 4; k++)
          if (!found && r[(m_ptr + k) % 4]) begin
            m_idx = (m_ptr + k) % 4;
            found = 1;
          end
        m_st = 1; m_vld = 1; m_busy = 1; m_cnt = 0;
      end
      1: begin
`ifdef RR_ARB4_WATCHDOG_EN
        wd = (m_cnt == MAX_HOLD - 1);
`else
        wd = 0;
`endif
        if (d || !r[m_idx] || wd) begin
          m_to  = wd && !d && r[m_idx];
          m_st  = 2;
          m_vld = 0;
          m_ptr = (m_idx + 1) % 4;
        end else if (m_cnt < (1 << CNT_W) - 1) begin
          m_cnt++;
        end
      end
      default: begin
        m_st = 0; m_busy = 0;
      end
    endcase
  endtask

  function automatic logic [4:0] m_out();
    return {2'(m_idx), m_vld, m_busy, m_to};
  endfunction

  task automatic step(input logic [3:0] r, input logic d);
    req = r; done = d;
    m_clock(r, d);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 4'b0000; done = 1'b0;
    m_reset();
    #12;
    n_vec++;
    if ({gnt_idx, gnt_valid, busy, timeout_err} !== 5'b00000) begin
      n_err++;
      $display("FAIL reset: got %b want 00000", {gnt_idx, gnt_valid, busy, timeout_err});
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_rotation();
    logic [1:0] seq [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    for (int g = 0; g < 5; g++) begin
      for (int s = 0; s < 4; s++) begin
        step(4'b1111, s == 2);
        n_vec++;
        if ({gnt_idx, gnt_valid, busy, timeout_err} !== m_out()) begin
          n_err++;
          $display("FAIL rotation g%0d s%0d: got %b want %b", g, s,
                   {gnt_idx, gnt_valid, busy, timeout_err}, m_out());
        end
        if (s == 0) begin
          n_vec++;
          if (gnt_idx !== seq[g] || gnt_valid !== 1'b1) begin
            n_err++;
            $display("FAIL rotation_order g%0d: got idx=%0d vld=%b want idx=%0d vld=1",
                     g, gnt_idx, gnt_valid, seq[g]);
          end
        end
      end
    end
  endtask

  task automatic test_skip_wrap();
    logic [3:0] r_seq [7] = '{4'b1000, 4'b1000, 4'b0000, 4'b0100, 4'b0100, 4'b0000, 4'b1001};
    logic       d_seq [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int s = 0; s < 7; s++) begin
      step(r_seq[s], d_seq[s]);
      n_vec++;
      if ({gnt_idx, gnt_valid, busy, timeout_err} !== m_out()) begin
        n_err++;
        $display("FAIL skip_wrap s%0d: got %b want %b", s,
                 {gnt_idx, gnt_valid, busy, timeout_err}, m_out());
      end
    end
    n_vec++;
    if (gnt_idx !== 2'd3 || gnt_valid !== 1'b1) begin
      n_err++;
      $display("FAIL skip_wrap_final: got idx=%0d vld=%b want idx=3 vld=1", gnt_idx, gnt_valid);
    end
    step(4'b1001, 1'b1);
    step(4'b0000, 1'b0);
  endtask

  task automatic test_req_drop();
    logic [3:0] r_seq [5] = '{4'b0010, 4'b0010, 4'b0000, 4'b1111, 4'b1111};
    for (int s = 0; s < 5; s++) begin
      step(r_seq[s], 1'b0);
      n_vec++;
      if ({gnt_idx, gnt_valid, busy, timeout_err} !== m_out()) begin
        n_err++;
        $display("FAIL req_drop s%0d: got %b want %b", s,
                 {gnt_idx, gnt_valid, busy, timeout_err}, m_out());
      end
    end
    n_vec++;
    if (gnt_idx !== 2'd2 || gnt_valid !== 1'b1) begin
      n_err++;
      $display("FAIL req_drop_next: got idx=%0d vld=%b want idx=2 vld=1", gnt_idx, gnt_valid);
    end
    step(4'b1111, 1'b1);
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b0);
  endtask

  task automatic test_reset_mid_grant();
    step(4'b0100, 1'b0);
    step(4'b0100, 1'b0);
    n_vec++;
    if (gnt_idx !== 2'd2 || gnt_valid !== 1'b1) begin
      n_err++;
      $display("FAIL mid_grant_setup: got idx=%0d vld=%b want idx=2 vld=1", gnt_idx, gnt_valid);
    end
    #3 rst_n = 1'b0;
    #1;
    m_reset();
    n_vec++;
    if ({gnt_idx, gnt_valid, busy, timeout_err} !== 5'b00000) begin
      n_err++;
      $display("FAIL async_reset: got %b want 00000", {gnt_idx, gnt_valid, busy, timeout_err});
    end
    req = 4'b0000;
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(4'b0001, 1'b0);
    n_vec++;
    if ({gnt_idx, gnt_valid, busy, timeout_err} !== 5'b00110 ||
        m_out() !== 5'b00110) begin
      n_err++;
      $display("FAIL post_reset_grant: got %b want 00110", {gnt_idx, gnt_valid, busy, timeout_err});
    end
    step(4'b0001, 1'b1);
    step(4'b0000, 1'b0);
  endtask

  task automatic test_long_hold(input bool_done_last);
    int hi, to_cnt, limit;
    hi = 0; to_cnt = 0;
`ifdef RR_ARB4_WATCHDOG_EN
    limit = 40;
`else
    limit = 100;
`endif
    step(4'b0001, 1'b0);
    for (int s = 0; s < limit + 4; s++) begin
      if (gnt_valid) hi++;
      if (timeout_err) to_cnt++;
      n_vec++;
      if ({gnt_idx, gnt_valid, busy, timeout_err} !== m_out()) begin
        n_err++;
        $display("FAIL hold s%0d: got %b want %b", s,
                 {gnt_idx, gnt_valid, busy, timeout_err}, m_out());
      end
`ifdef RR_ARB4_WATCHDOG_EN
      if (!gnt_valid && !busy) break;
      step(4'b0001, bool_done_last && hi == MAX_HOLD && gnt_valid);
`else
      if (s == limit - 1) break;
      step(4'b0001, 1'b0);
`endif
    end
`ifdef RR_ARB4_WATCHDOG_EN
    n_vec++;
    if (hi !== MAX_HOLD || to_cnt !== (bool_done_last ? 0 : 1)) begin
      n_err++;
      $display("FAIL watchdog done=%0d: got hi=%0d to=%0d want hi=%0d to=%0d",
               bool_done_last, hi, to_cnt, MAX_HOLD, bool_done_last ? 0 : 1);
    end
`else
    n_vec++;
    if (hi !== limit || to_cnt !== 0) begin
      n_err++;
      $display("FAIL long_hold: got hi=%0d to=%0d want hi=%0d to=0", hi, to_cnt, limit);
    end
    step(4'b0001, 1'b1);
    step(4'b0000, 1'b0);
`endif
    step(4'b0000, 1'b0);
  endtask

  task automatic test_random();
    logic [3:0] r;
    r = 4'b0000;
    for (int s = 0; s < 400; s++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
      step(r, $urandom_range(0, 5) == 0);
      n_vec++;
      if ({gnt_idx, gnt_valid, busy, timeout_err} !== m_out()) begin
        n_err++;
        $display("FAIL random s%0d: got %b want %b", s,
                 {gnt_idx, gnt_valid, busy, timeout_err}, m_out());
      end
    end
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_skip_wrap();
    test_req_drop();
    test_reset_mid_grant();
    test_long_hold(1'b0);
`ifdef RR_ARB4_WATCHDOG_EN
    test_long_hold(1'b1);
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
